// File: rtl/grid_pkg.sv
// Shared types and constants for the LED-matrix grid scan driver.
package grid_pkg;

  localparam int GRID_ROWS = 8;
  localparam int GRID_COLS = 8;
  localparam int GRID_BITS = GRID_ROWS * GRID_COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SCAN  = 2'd2,
    BLANK = 2'd3
  } scan_state_t;

  // Width of a down-counter able to hold the larger of two cycle counts.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter with a zero flag; times both the row dwell and the
// blanking gap. Saturates at zero, so it can never wrap.
module scan_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Count register: load wins, otherwise decrement until zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/grid_scan_driver.sv
// Row-scans a snapshot of the Life grid onto a multiplexed LED matrix.
// The grid is captured only in the LOAD cycle at a frame boundary, so a
// generation change never tears a frame in progress.
module grid_scan_driver
  import grid_pkg::*;
#(
  parameter int ROWS      = GRID_ROWS,
  parameter int COLS      = GRID_COLS,
  parameter int DWELL     = 1000,
  parameter int BLANK_CYC = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] grid,
  input  logic                 grid_valid,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_data,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int CW = cnt_width(DWELL, BLANK_CYC);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  scan_state_t            state_r, state_s;
  logic [RW-1:0]          row_r, row_s;
  logic [ROWS*COLS-1:0]   shadow_r, shadow_s;
  logic                   pending_r, pending_s;
  logic                   tmr_load_s;
  logic [CW-1:0]          tmr_val_s;
  logic                   tmr_zero_s;
  logic                   frame_done_s;
  logic [ROWS-1:0]        row_sel_r, row_sel_s;
  logic [COLS-1:0]        col_data_r, col_data_s;
  logic                   frame_done_r;
  logic                   busy_r;

  scan_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state logic: frame sequencing, snapshot capture and pending tracking.
  always_comb begin
    state_s      = state_r;
    row_s        = row_r;
    shadow_s     = shadow_r;
    pending_s    = pending_r | grid_valid;
    tmr_load_s   = 1'b0;
    tmr_val_s    = {CW{1'b0}};
    frame_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        row_s      = {RW{1'b0}};
        state_s    = SCAN;
        tmr_load_s = 1'b1;
        tmr_val_s  = DWELL_LD;
        if (pending_r) begin
          // A grid_valid arriving with this capture is already consumed.
          shadow_s  = grid;
          pending_s = 1'b0;
        end else begin
          shadow_s  = shadow_r;
        end
      end
      SCAN: begin
        if (tmr_zero_s) begin
          state_s    = BLANK;
          tmr_load_s = 1'b1;
          tmr_val_s  = BLANK_LD;
        end else begin
          state_s    = SCAN;
        end
      end
      BLANK: begin
        if (tmr_zero_s) begin
          if (row_r == LAST_ROW) begin
            // Frame boundary: the only point besides IDLE where enable matters.
            frame_done_s = 1'b1;
            state_s      = enable ? LOAD : IDLE;
          end else begin
            row_s      = row_r + RW'(1);
            state_s    = SCAN;
            tmr_load_s = 1'b1;
            tmr_val_s  = DWELL_LD;
          end
        end else begin
          state_s = BLANK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    row_sel_s  = {ROWS{1'b0}};
    col_data_s = {COLS{1'b0}};
    if (state_s == SCAN) begin
      row_sel_s[row_s] = 1'b1;
      col_data_s       = shadow_s[row_s*COLS +: COLS];
    end else begin
      row_sel_s  = {ROWS{1'b0}};
      col_data_s = {COLS{1'b0}};
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      row_r        <= {RW{1'b0}};
      shadow_r     <= {(ROWS*COLS){1'b0}};
      pending_r    <= 1'b1;
      row_sel_r    <= {ROWS{1'b0}};
      col_data_r   <= {COLS{1'b0}};
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      row_r        <= row_s;
      shadow_r     <= shadow_s;
      pending_r    <= pending_s;
      row_sel_r    <= row_sel_s;
      col_data_r   <= col_data_s;
      frame_done_r <= frame_done_s;
      busy_r       <= (state_s != IDLE);
    end
  end

  assign row_sel    = row_sel_r;
  assign col_data   = col_data_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_grid_scan_driver.sv
// Directed bench for grid_scan_driver with DWELL=4, BLANK_CYC=2 (frame = 49 cycles).
module tb_grid_scan_driver;

  localparam int DW = 4;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] grid;
  logic        grid_valid;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic        busy;

  grid_scan_driver #(.ROWS(8), .COLS(8), .DWELL(DW), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .grid       (grid),
    .grid_valid (grid_valid),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] grid;
    logic        enable;
    logic        grid_valid;
    logic [7:0]  rs;
    logic [7:0]  cd;
    logic        fd;
    logic        busy;
  } rst_vec_t;

  typedef struct {
    logic [7:0] rs;
    logic [7:0] cd;
  } row_vec_t;

  rst_vec_t rv[4];
  row_vec_t exp_rows[8];
  int checks   = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] rs, input logic [7:0] cd,
                          input logic fd, input logic bz);
    chk({tag, " row_sel"}, row_sel, rs);
    chk({tag, " col_data"}, col_data, cd);
    chk({tag, " frame_done"}, {7'd0, frame_done}, {7'd0, fd});
    chk({tag, " busy"}, {7'd0, busy}, {7'd0, bz});
  endtask

  // kind 0: diagonal 8040_2010_0804_0201; 1: only row 0 = FF; 2: only row 7 = FF
  task automatic set_rows(input int kind);
    for (int k = 0; k < 8; k++) begin
      exp_rows[k].rs = 8'h01 << k;
      case (kind)
        0: exp_rows[k].cd = 8'h01 << k;
        1: exp_rows[k].cd = (k == 0) ? 8'hFF : 8'h00;
        default: exp_rows[k].cd = (k == 7) ? 8'hFF : 8'h00;
      endcase
    end
  endtask

  // Starts in a LOAD cycle; ends in the following boundary cycle (frame_done high).
  task automatic check_frame(input string tag, input int vrow, input logic [63:0] vgrid,
                             input int drow, input logic end_busy);
    for (int r = 0; r < 8; r++) begin
      for (int d = 0; d < DW; d++) begin
        tick();
        grid_valid = 1'b0;
        chk_outs($sformatf("%s r%0d d%0d", tag, r, d), exp_rows[r].rs, exp_rows[r].cd, 1'b0, 1'b1);
        if (r == vrow && d == 0) begin
          grid       = vgrid;
          grid_valid = 1'b1;
        end
        if (r == drow && d == 0) begin
          enable = 1'b0;
        end
      end
      for (int b = 0; b < BC; b++) begin
        tick();
        grid_valid = 1'b0;
        chk_outs($sformatf("%s r%0d blank%0d", tag, r, b), 8'h00, 8'h00, 1'b0, 1'b1);
      end
    end
    tick();
    chk_outs({tag, " boundary"}, 8'h00, 8'h00, 1'b1, end_busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    rv[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    rv[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    rv[3] = '{64'h8040_2010_0804_0201, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

    reset      = 1'b0;
    enable     = 1'b1;
    grid       = 64'hFFFF_FFFF_FFFF_FFFF;
    grid_valid = 1'b0;

    // Test 1: held in reset, outputs stay dark regardless of inputs.
    for (int i = 0; i < 4; i++) begin
      grid       = rv[i].grid;
      enable     = rv[i].enable;
      grid_valid = rv[i].grid_valid;
      tick();
      chk_outs($sformatf("reset v%0d", i), rv[i].rs, rv[i].cd, rv[i].fd, rv[i].busy);
    end
    grid_valid = 1'b0;

    // Test 2: release; LOAD next cycle, then diagonal frame.
    reset = 1'b1;
    tick();
    chk_outs("load1", 8'h00, 8'h00, 1'b0, 1'b1);
    set_rows(0);
    // Test 3a: new grid mid-frame is held off until the next frame.
    check_frame("f1", 5, 64'h0000_0000_0000_00FF, -1, 1'b1);
    set_rows(1);
    check_frame("f2", 3, 64'hFF00_0000_0000_0000, -1, 1'b1);
    set_rows(2);
    check_frame("f3", -1, 64'h0, -1, 1'b1);
    // Grid changes without grid_valid must not be picked up.
    grid = 64'h1234_5678_9ABC_DEF0;
    // Test 4: enable dropped in row 3; frame finishes and goes idle.
    check_frame("f4", -1, 64'h0, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs($sformatf("idle%0d", i), 8'h00, 8'h00, 1'b0, 1'b0);
    end

    // Test 5: reset during row 5 SCAN.
    enable = 1'b1;
    tick();
    chk_outs("load5", 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5 * (DW + BC) + 2; i++) begin
      tick();
    end
    chk_outs("row5", 8'h20, 8'h00, 1'b0, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    chk_outs("async reset", 8'h00, 8'h00, 1'b0, 1'b0);
    grid = 64'h8040_2010_0804_0201;
    tick();
    reset = 1'b1;
    tick();
    chk_outs("load6", 8'h00, 8'h00, 1'b0, 1'b1);
    set_rows(0);
    check_frame("f6", -1, 64'h0, 0, 1'b0);
    tick();
    chk_outs("final idle", 8'h00, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
